// File: rtl/ticket_sell_if.sv
// Handshake and result bundle between the ticket vending front end and
// the ticket/change controller.
interface ticket_sell_if;
  logic [7:0] credit;
  logic [1:0] price_sel;
  logic [1:0] qty;
  logic       buy;
  logic       cancel;
  logic       ticket_out;
  logic       chg50;
  logic       chg10;
  logic       chg5;
  logic       chg1;
  logic [7:0] chg_total;
  logic       clr_credit;
  logic       err_insufficient;
  logic       busy;

  modport master (
    output credit, price_sel, qty, buy, cancel,
    input  ticket_out, chg50, chg10, chg5, chg1, chg_total,
           clr_credit, err_insufficient, busy
  );

  modport slave (
    input  credit, price_sel, qty, buy, cancel,
    output ticket_out, chg50, chg10, chg5, chg1, chg_total,
           clr_credit, err_insufficient, busy
  );
endinterface

// File: rtl/ticket_sell_ctrl.sv
// Ticket sale controller: validates a purchase against the inserted credit,
// issues one ticket pulse per ticket, pays change greedily (50/10/5/1) and
// clears the upstream coin counter when a sale or refund completes.
module ticket_sell_ctrl #(
  parameter logic [7:0] PRICE0 = 8'd5,
  parameter logic [7:0] PRICE1 = 8'd10,
  parameter logic [7:0] PRICE2 = 8'd20,
  parameter logic [7:0] PRICE3 = 8'd50
) (
  input logic         clk,
  input logic         rst,
  ticket_sell_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHECK, DISPENSE, CHANGE, DONE} state_e;

  state_e     state_q;
  logic [7:0] credit_q;
  logic [1:0] sel_q;
  logic [1:0] qty_q;
  logic [1:0] cnt_q;
  logic [7:0] remain_q;
  logic [7:0] chg_total_q;
  logic       ticket_out_q;
  logic       chg50_q;
  logic       chg10_q;
  logic       chg5_q;
  logic       chg1_q;
  logic       clr_credit_q;
  logic       err_q;
  logic       busy_q;

  logic [7:0] price_d;
  logic [7:0] cost_d;
  logic [7:0] coin_d;

  // Price of the latched selection times the latched quantity; at most 150.
  always_comb begin
    price_d = PRICE0;
    case (sel_q)
      2'd1:    price_d = PRICE1;
      2'd2:    price_d = PRICE2;
      2'd3:    price_d = PRICE3;
      default: price_d = PRICE0;
    endcase
    cost_d = price_d * {6'd0, qty_q};
  end

  // Largest coin that still fits in the remaining change.
  always_comb begin
    coin_d = 8'd1;
    if (remain_q >= 8'd50)      coin_d = 8'd50;
    else if (remain_q >= 8'd10) coin_d = 8'd10;
    else if (remain_q >= 8'd5)  coin_d = 8'd5;
  end

  // Sale FSM; every output is a register updated together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      credit_q     <= 8'd0;
      sel_q        <= 2'd0;
      qty_q        <= 2'd0;
      cnt_q        <= 2'd0;
      remain_q     <= 8'd0;
      chg_total_q  <= 8'd0;
      ticket_out_q <= 1'b0;
      chg50_q      <= 1'b0;
      chg10_q      <= 1'b0;
      chg5_q       <= 1'b0;
      chg1_q       <= 1'b0;
      clr_credit_q <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ticket_out_q <= 1'b0;
      chg50_q      <= 1'b0;
      chg10_q      <= 1'b0;
      chg5_q       <= 1'b0;
      chg1_q       <= 1'b0;
      clr_credit_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cancel) begin
            if (bus.credit != 8'd0) begin
              remain_q    <= bus.credit;
              chg_total_q <= bus.credit;
              state_q     <= CHANGE;
              busy_q      <= 1'b1;
            end
          end else if (bus.buy) begin
            credit_q    <= bus.credit;
            sel_q       <= bus.price_sel;
            qty_q       <= bus.qty;
            chg_total_q <= 8'd0;
            state_q     <= CHECK;
            busy_q      <= 1'b1;
          end
        end
        CHECK: begin
          if ((qty_q == 2'd0) || (credit_q < cost_d)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            remain_q    <= credit_q - cost_d;
            chg_total_q <= credit_q - cost_d;
            cnt_q       <= qty_q;
            state_q     <= DISPENSE;
          end
        end
        DISPENSE: begin
          ticket_out_q <= 1'b1;
          cnt_q        <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_q <= CHANGE;
        end
        CHANGE: begin
          if (remain_q == 8'd0) begin
            clr_credit_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            chg50_q  <= (coin_d == 8'd50);
            chg10_q  <= (coin_d == 8'd10);
            chg5_q   <= (coin_d == 8'd5);
            chg1_q   <= (coin_d == 8'd1);
            remain_q <= remain_q - coin_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ticket_out       = ticket_out_q;
  assign bus.chg50            = chg50_q;
  assign bus.chg10            = chg10_q;
  assign bus.chg5             = chg5_q;
  assign bus.chg1             = chg1_q;
  assign bus.chg_total        = chg_total_q;
  assign bus.clr_credit       = clr_credit_q;
  assign bus.err_insufficient = err_q;
  assign bus.busy             = busy_q;

endmodule

// File: doc/ticket_sell_ctrl.md
TICKET_SELL_CTRL -- requirements
Module: ticket_sell_ctrl

Interface
REQ-001 The block SHALL have parameter PRICE0, default 5, meaning ticket price for price_sel=0.
REQ-002 The block SHALL have parameter PRICE1, default 10, meaning ticket price for price_sel=1.
REQ-003 The block SHALL have parameter PRICE2, default 20, meaning ticket price for price_sel=2.
REQ-004 The block SHALL have parameter PRICE3, default 50, meaning ticket price for price_sel=3.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-006 The block SHALL have port credit, input, 8 bits, running inserted total from the upstream coin counter.
REQ-007 The block SHALL have port price_sel, input, 2 bits, selecting the ticket price.
REQ-008 The block SHALL have port qty, input, 2 bits, giving the ticket quantity; 0 is invalid.
REQ-009 The block SHALL have ports buy and cancel, each input, 1 bit, single-cycle request pulses.
REQ-010 The block SHALL have port ticket_out, output, 1 bit, one pulse per ticket issued.
REQ-011 The block SHALL have ports chg50, chg10, chg5 and chg1, each output, 1 bit, one pulse per change coin.
REQ-012 The block SHALL have port chg_total, output, 8 bits, the latched change or refund amount.
REQ-013 The block SHALL have port clr_credit, output, 1 bit, a pulse that clears the upstream counter.
REQ-014 The block SHALL have port err_insufficient, output, 1 bit, a pulse on a rejected purchase.
REQ-015 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, CHECK, DISPENSE, CHANGE and DONE; all outputs SHALL be registered.
REQ-017 In IDLE, when buy=1, the block SHALL latch credit, price_sel and qty and go to CHECK on the next cycle.
REQ-018 In IDLE, when cancel=1 and credit>0, the block SHALL latch remain=credit and chg_total=credit and go to CHANGE; cancel with credit=0 SHALL be ignored.
REQ-019 When buy and cancel are both high in the same cycle, cancel SHALL win.
REQ-020 buy and cancel SHALL be ignored in every state except IDLE; cancel is not accepted after CHECK.
REQ-021 CHECK SHALL last exactly 1 cycle and compute cost = PRICE[sel]*qty in 8 bits (max 150, no overflow).
REQ-022 If qty=0 or latched credit < cost, the block SHALL pulse err_insufficient for 1 cycle and return to IDLE, with no clr_credit and no ticket.
REQ-023 Otherwise the block SHALL set remain = credit - cost, set chg_total = remain, load the ticket counter with qty, and go to DISPENSE.
REQ-024 In DISPENSE, the block SHALL pulse ticket_out once per cycle, decrementing the counter, and go to CHANGE after the last pulse.
REQ-025 Latency SHALL be: buy sampled at cycle N -> CHECK at N+1 -> first ticket_out at N+2.
REQ-026 In CHANGE, each cycle the block SHALL pulse exactly one of chg50, chg10, chg5 or chg1, choosing the largest coin <= remain (greedy), and subtract that coin from remain.
REQ-027 When CHANGE is entered with remain=0, or remain reaches 0, the block SHALL go to DONE with no coin pulse in that cycle.
REQ-028 DONE SHALL pulse clr_credit for 1 cycle and then return to IDLE.
REQ-029 No two change pulses SHALL be high in the same cycle, and ticket_out and the change pulses SHALL never overlap.
REQ-030 chg_total SHALL hold its value until the next accepted buy or cancel.

Reset
REQ-031 While rst=1 at a clock edge, the state SHALL go to IDLE.
REQ-032 While rst=1 at a clock edge, all outputs, remain and the ticket counter SHALL go to 0.
REQ-033 Reset SHALL take precedence over all other inputs.
REQ-034 Reset asserted mid-DISPENSE or mid-CHANGE SHALL abort the sale with no further pulses and no clr_credit.

Verification
REQ-035 The bench SHALL cover: rst held 2 cycles -> all outputs 0, busy=0.
REQ-036 The bench SHALL cover: credit=66, price_sel=1, qty=2, buy -> ticket_out at N+2 and N+3; chg_total=46; change pulses 10,10,10,10,5,1; then clr_credit; then busy=0.
REQ-037 The bench SHALL cover: credit=15, price_sel=2, qty=1, buy -> err_insufficient at N+1; no ticket_out; no clr_credit; busy=0 at N+2.
REQ-038 The bench SHALL cover: credit=57, cancel -> change pulses 50,5,1,1; clr_credit; no ticket_out.
REQ-039 The bench SHALL cover: credit=150, price_sel=3, qty=3, buy -> 3 ticket_out pulses; no change pulses; chg_total=0; clr_credit.
REQ-040 The bench SHALL cover: rst asserted after the 1st ticket_out of a qty=3 sale -> all outputs 0 on the next cycle; IDLE; no clr_credit.
